rename_stg1: RTL and testbench

Rename stage 1: registers one 4-instruction rename group from rename stage 0 and resolves intra-group dependencies before handing the group to dispatch.

- Stage 0 supplies, per slot:
  - RAT-read source mappings and the old destination mapping.
  - Freshly allocated destination registers.
  - The 2-bit dependency select codes.
- This block muxes each source and old-destination mapping from an earlier slot's new destination where the select code says so.
- It holds the result in a valid/ready pipeline register and counts renamed groups.

---
 rtl/rename_stg1_if.sv | 40 ++++
 rtl/rename_stg1.sv | 135 +++++++++++++
 tb/tb_rename_stg1.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rename_stg1_if.sv
// Rename stage 1 group bus: stage 0 inputs, dispatch outputs, flush and the group counter.
// slave is the stage itself, master the surrounding pipeline.
interface rename_stg1_if #(
    parameter int unsigned PREG_W = 7,
    parameter int unsigned CNT_W  = 32
);
    logic                  flush_i;
    logic                  in_vld_i;
    logic                  in_rdy_o;
    logic [3:0]            slot_vld_i;
    logic [4*PREG_W-1:0]   ps1_i;
    logic [4*PREG_W-1:0]   ps2_i;
    logic [4*PREG_W-1:0]   pd_new_i;
    logic [4*PREG_W-1:0]   pd_old_i;
    logic [3:0]            rd_vld_i;
    logic [7:0]            rs1_sel_i;
    logic [7:0]            rs2_sel_i;
    logic [7:0]            rd_sel_i;
    logic                  out_vld_o;
    logic                  out_rdy_i;
    logic [3:0]            slot_vld_o;
    logic [4*PREG_W-1:0]   ps1_o;
    logic [4*PREG_W-1:0]   ps2_o;
    logic [4*PREG_W-1:0]   pd_o;
    logic [4*PREG_W-1:0]   ppd_o;
    logic [3:0]            rd_vld_o;
    logic [CNT_W-1:0]      grp_cnt_o;

    modport master (
        output flush_i, in_vld_i, slot_vld_i, ps1_i, ps2_i, pd_new_i, pd_old_i, rd_vld_i,
        output rs1_sel_i, rs2_sel_i, rd_sel_i, out_rdy_i,
        input  in_rdy_o, out_vld_o, slot_vld_o, ps1_o, ps2_o, pd_o, ppd_o, rd_vld_o, grp_cnt_o
    );

    modport slave (
        input  flush_i, in_vld_i, slot_vld_i, ps1_i, ps2_i, pd_new_i, pd_old_i, rd_vld_i,
        input  rs1_sel_i, rs2_sel_i, rd_sel_i, out_rdy_i,
        output in_rdy_o, out_vld_o, slot_vld_o, ps1_o, ps2_o, pd_o, ppd_o, rd_vld_o, grp_cnt_o
    );
endinterface

// File: rtl/rename_stg1.sv
// Rename stage 1: resolves intra-group dependencies and registers the 4-slot group for dispatch.
// Optional feature macro RN_S1_SKID_EN adds a skid entry with a registered in_rdy_o.
module rename_stg1 #(
    parameter int unsigned PREG_W = 7,
    parameter int unsigned CNT_W  = 32
) (
    input logic         clk_i,
    input logic         rstn_i,
    rename_stg1_if.slave bus
);
    localparam int unsigned SW    = 4 * PREG_W;
    localparam int unsigned GRP_W = 8 + 4 * SW;

    logic [SW-1:0]    w_ps1;
    logic [SW-1:0]    w_ps2;
    logic [SW-1:0]    w_ppd;
    logic [GRP_W-1:0] w_grp;
    logic             w_in_rdy;
    logic             w_acc;

    logic             r_out_vld;
    logic [GRP_W-1:0] r_out_grp;
    logic [CNT_W-1:0] r_cnt;

    // A select code only overrides the RAT value when it names an earlier slot.
    always_comb begin
        w_ps1 = bus.ps1_i;
        w_ps2 = bus.ps2_i;
        w_ppd = bus.pd_old_i;
        for (int n = 1; n < 4; n++) begin
            for (int k = 0; k < n; k++) begin
                if (bus.rs1_sel_i[2*n +: 2] == 2'(k)) begin
                    w_ps1[n*PREG_W +: PREG_W] = bus.pd_new_i[k*PREG_W +: PREG_W];
                end
                if (bus.rs2_sel_i[2*n +: 2] == 2'(k)) begin
                    w_ps2[n*PREG_W +: PREG_W] = bus.pd_new_i[k*PREG_W +: PREG_W];
                end
                if (bus.rd_vld_i[n] && (bus.rd_sel_i[2*n +: 2] == 2'(k))) begin
                    w_ppd[n*PREG_W +: PREG_W] = bus.pd_new_i[k*PREG_W +: PREG_W];
                end
            end
        end
    end

    assign w_grp = {bus.slot_vld_i, bus.rd_vld_i, w_ps1, w_ps2, bus.pd_new_i, w_ppd};
    assign w_acc = bus.in_vld_i && w_in_rdy && !bus.flush_i;

    assign bus.in_rdy_o  = w_in_rdy;
    assign bus.out_vld_o = r_out_vld;
    assign bus.grp_cnt_o = r_cnt;
    assign {bus.slot_vld_o, bus.rd_vld_o, bus.ps1_o, bus.ps2_o, bus.pd_o, bus.ppd_o} = r_out_grp;

`ifdef RN_S1_SKID_EN
    logic             r_in_rdy;
    logic             r_sk_vld;
    logic [GRP_W-1:0] r_sk_grp;
    logic             w_out_free;
    logic             w_illegal;

    assign w_in_rdy   = r_in_rdy;
    assign w_out_free = !r_out_vld || bus.out_rdy_i;

    // in_rdy_o is low only while the skid entry holds a group, so no accept collides with it.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_out_vld <= 1'b0;
            r_out_grp <= '0;
            r_sk_vld  <= 1'b0;
            r_sk_grp  <= '0;
            r_in_rdy  <= 1'b1;
            r_cnt     <= '0;
        end else begin
            if (w_acc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (bus.flush_i) begin
                r_out_vld <= 1'b0;
                r_sk_vld  <= 1'b0;
                r_in_rdy  <= 1'b1;
            end else if (w_out_free) begin
                if (r_sk_vld) begin
                    r_out_grp <= r_sk_grp;
                    r_out_vld <= 1'b1;
                    r_sk_vld  <= 1'b0;
                    r_in_rdy  <= 1'b1;
                end else if (w_acc) begin
                    r_out_grp <= w_grp;
                    r_out_vld <= 1'b1;
                end else begin
                    r_out_vld <= 1'b0;
                end
            end else if (w_acc) begin
                r_sk_grp <= w_grp;
                r_sk_vld <= 1'b1;
                r_in_rdy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_illegal = 1'b0;
        for (int n = 0; n < 4; n++) begin
            if (bus.in_vld_i && bus.slot_vld_i[n] &&
                ((int'(bus.rs1_sel_i[2*n +: 2]) > n) || (int'(bus.rs2_sel_i[2*n +: 2]) > n) ||
                 (int'(bus.rd_sel_i[2*n +: 2]) > n))) begin
                w_illegal = 1'b1;
            end
        end
    end

    a_sel_legal: assert property (@(posedge clk_i) disable iff (!rstn_i) !w_illegal);
`else
    assign w_in_rdy = !r_out_vld || bus.out_rdy_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_out_vld <= 1'b0;
            r_out_grp <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_acc) begin
                r_out_grp <= w_grp;
                r_cnt     <= r_cnt + CNT_W'(1);
            end
            if (bus.flush_i) begin
                r_out_vld <= 1'b0;
            end else if (w_acc) begin
                r_out_vld <= 1'b1;
            end else if (bus.out_rdy_i) begin
                r_out_vld <= 1'b0;
            end
        end
    end
`endif
endmodule

// File: tb/tb_rename_stg1.sv
// Scoreboard bench for rename_stg1 (default build): directed groups with hand-computed results.
module tb_rename_stg1;
    localparam int unsigned PW = 7;
    localparam int unsigned CW = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    rename_stg1_if #(.PREG_W(PW), .CNT_W(CW)) bus ();
    rename_stg1 #(.PREG_W(PW), .CNT_W(CW)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));

    typedef struct {
        logic [3:0]  sv, rv;
        logic [27:0] ps1, ps2, pdn, pdo;
        logic [7:0]  s1, s2, sd;
    } vec_t;
    typedef struct {
        logic [3:0]  sv, rv;
        logic [27:0] ps1, ps2, pd, ppd;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic logic [27:0] pk(input logic [6:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Independent group: every select names its own slot, so all values pass straight through.
    function automatic vec_t simple(input logic [6:0] b);
        vec_t v;
        v = '{sv: 4'hF, rv: 4'hF, s1: 8'hE4, s2: 8'hE4, sd: 8'hE4,
              ps1: pk(b, b + 7'd1, b + 7'd2, b + 7'd3),
              ps2: pk(b + 7'd4, b + 7'd5, b + 7'd6, b + 7'd7),
              pdn: pk(b + 7'd8, b + 7'd9, b + 7'd10, b + 7'd11),
              pdo: pk(b + 7'd12, b + 7'd13, b + 7'd14, b + 7'd15)};
        return v;
    endfunction

    function automatic exp_t pass(input vec_t v);
        exp_t e;
        e = '{sv: v.sv, rv: v.rv, ps1: v.ps1, ps2: v.ps2, pd: v.pdn, ppd: v.pdo};
        return e;
    endfunction

    task automatic drive(input vec_t v);
        bus.slot_vld_i = v.sv;
        bus.rd_vld_i   = v.rv;
        bus.ps1_i      = v.ps1;
        bus.ps2_i      = v.ps2;
        bus.pd_new_i   = v.pdn;
        bus.pd_old_i   = v.pdo;
        bus.rs1_sel_i  = v.s1;
        bus.rs2_sel_i  = v.s2;
        bus.rd_sel_i   = v.sd;
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns 1 time unit after the edge that accepted the group.
    task automatic send(input vec_t v, input exp_t e);
        bit ok;
        ok = 1'b0;
        drive(v);
        bus.in_vld_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_rdy_o && !bus.flush_i) begin
                q.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: in_rdy_o stayed 0 for 20 cycles, required 1");
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rstn && bus.out_vld_o && bus.out_rdy_i) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_group: got out_vld_o=1, required no group");
            end else begin
                e = q.pop_front();
                chk("slot_vld_o", 64'(bus.slot_vld_o), 64'(e.sv));
                chk("rd_vld_o", 64'(bus.rd_vld_o), 64'(e.rv));
                chk("ps1_o", 64'(bus.ps1_o), 64'(e.ps1));
                chk("ps2_o", 64'(bus.ps2_o), 64'(e.ps2));
                chk("pd_o", 64'(bus.pd_o), 64'(e.pd));
                chk("ppd_o", 64'(bus.ppd_o), 64'(e.ppd));
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_out_vld"}, 64'(bus.out_vld_o), 64'(0));
        chk({tag, "_grp_cnt"}, 64'(bus.grp_cnt_o), 64'(0));
        chk({tag, "_slot_vld"}, 64'(bus.slot_vld_o), 64'(0));
        chk({tag, "_rd_vld"}, 64'(bus.rd_vld_o), 64'(0));
        chk({tag, "_ps1"}, 64'(bus.ps1_o), 64'(0));
        chk({tag, "_ps2"}, 64'(bus.ps2_o), 64'(0));
        chk({tag, "_pd"}, 64'(bus.pd_o), 64'(0));
        chk({tag, "_ppd"}, 64'(bus.ppd_o), 64'(0));
        chk({tag, "_in_rdy"}, 64'(bus.in_rdy_o), 64'(1));
    endtask

    vec_t v1, v2, v3, va, vb, vc;
    exp_t e1, e2, e3;

    initial begin
        bus.flush_i   = 1'b0;
        bus.in_vld_i  = 1'b0;
        bus.out_rdy_i = 1'b1;
        drive(simple(7'd0));

        v1 = '{sv: 4'hF, rv: 4'hF, s1: 8'hE4, s2: 8'hE4, sd: 8'hE4,
               ps1: pk(7'h10, 7'h11, 7'h12, 7'h15), ps2: pk(7'h20, 7'h21, 7'h22, 7'h23),
               pdn: pk(7'h30, 7'h31, 7'h32, 7'h33), pdo: pk(7'h50, 7'h51, 7'h52, 7'h22)};
        e1 = pass(v1);
        // Slot 3 chains: rs1 from slot 2, rs2 from slot 0, old rd from slot 1.
        v2 = '{sv: 4'hF, rv: 4'hF, s1: 8'hA4, s2: 8'h24, sd: 8'h64,
               ps1: pk(7'h01, 7'h02, 7'h03, 7'h04), ps2: pk(7'h05, 7'h06, 7'h07, 7'h08),
               pdn: pk(7'h40, 7'h41, 7'h42, 7'h43), pdo: pk(7'h09, 7'h0A, 7'h0B, 7'h0C)};
        e2 = '{sv: 4'hF, rv: 4'hF,
               ps1: pk(7'h01, 7'h02, 7'h03, 7'h42), ps2: pk(7'h05, 7'h06, 7'h07, 7'h40),
               pd: pk(7'h40, 7'h41, 7'h42, 7'h43), ppd: pk(7'h09, 7'h0A, 7'h0B, 7'h41)};
        // Slot 1 rs2 sel 3 is illegal (own value kept); slot 2 rd sel ignored as rd_vld=0.
        v3 = '{sv: 4'h7, rv: 4'hB, s1: 8'hE0, s2: 8'hDC, sd: 8'h80,
               ps1: pk(7'h01, 7'h02, 7'h03, 7'h04), ps2: pk(7'h11, 7'h12, 7'h13, 7'h14),
               pdn: pk(7'h60, 7'h61, 7'h62, 7'h63), pdo: pk(7'h21, 7'h22, 7'h23, 7'h24)};
        e3 = '{sv: 4'h7, rv: 4'hB,
               ps1: pk(7'h01, 7'h60, 7'h03, 7'h04), ps2: pk(7'h11, 7'h12, 7'h61, 7'h14),
               pd: pk(7'h60, 7'h61, 7'h62, 7'h63), ppd: pk(7'h21, 7'h60, 7'h23, 7'h62)};

        // Reset state
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_in_rdy", 64'(bus.in_rdy_o), 64'(1));
        @(posedge clk);
        #1;

        // Independent group, 1-cycle latency
        send(v1, e1);
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("v1_out_vld", 64'(bus.out_vld_o), 64'(1));
        chk("v1_grp_cnt", 64'(bus.grp_cnt_o), 64'(1));
        chk("v1_ps1_slot3", 64'(bus.ps1_o[3*PW +: PW]), 64'(7'h15));
        chk("v1_ppd_slot3", 64'(bus.ppd_o[3*PW +: PW]), 64'(7'h22));
        @(posedge clk);
        #1;

        // Back-to-back dependent groups
        send(v2, e2);
        send(v3, e3);
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("b2b_grp_cnt", 64'(bus.grp_cnt_o), 64'(3));
        cyc(2);

        // Backpressure: A held, B waits, then B follows A with no bubble
        va = simple(7'h10);
        vb = simple(7'h30);
        vc = simple(7'h50);
        bus.out_rdy_i = 1'b0;
        send(va, pass(va));
        drive(vb);
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_rdy", 64'(bus.in_rdy_o), 64'(0));
            chk("stall_out_vld", 64'(bus.out_vld_o), 64'(1));
            chk("stall_ps1_hold", 64'(bus.ps1_o), 64'(va.ps1));
            @(posedge clk);
            #1;
        end
        bus.out_rdy_i = 1'b1;
        send(vb, pass(vb));
        chk("no_bubble_out_vld", 64'(bus.out_vld_o), 64'(1));
        send(vc, pass(vc));
        bus.in_vld_i = 1'b0;
        cyc(1);

        // Flush with a held group and an incoming group
        bus.out_rdy_i = 1'b0;
        send(simple(7'h20), pass(simple(7'h20)));
        drive(simple(7'h40));
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i  = 1'b0;
        bus.in_vld_i = 1'b0;
        void'(q.pop_back());
        @(negedge clk);
        chk("flush_out_vld", 64'(bus.out_vld_o), 64'(0));
        chk("flush_grp_cnt", 64'(bus.grp_cnt_o), 64'(7));
        chk("flush_in_rdy", 64'(bus.in_rdy_o), 64'(1));
        // Flush while the stage is ready: the incoming group must still be dropped
        @(posedge clk);
        #1;
        bus.out_rdy_i = 1'b1;
        bus.in_vld_i  = 1'b1;
        bus.flush_i   = 1'b1;
        @(posedge clk);
        #1;
        bus.flush_i  = 1'b0;
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("flush2_out_vld", 64'(bus.out_vld_o), 64'(0));
        chk("flush2_grp_cnt", 64'(bus.grp_cnt_o), 64'(7));
        cyc(1);

        // Reach grp_cnt = 5 (through a wrap) with a group held, then reset
        for (int i = 0; i < 13; i++) begin
            send(simple(7'(i * 7)), pass(simple(7'(i * 7))));
        end
        bus.in_vld_i = 1'b0;
        cyc(1);
        bus.out_rdy_i = 1'b0;
        send(simple(7'h33), pass(simple(7'h33)));
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("pre_reset_grp_cnt", 64'(bus.grp_cnt_o), 64'(5));
        chk("pre_reset_out_vld", 64'(bus.out_vld_o), 64'(1));
        @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
        q.delete();
        @(negedge clk);
        chk_zero("midreset");
        @(posedge clk);
        #1 bus.out_rdy_i = 1'b1;

        // 17 accepted groups on a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            send(simple(7'(i * 6)), pass(simple(7'(i * 6))));
        end
        bus.in_vld_i = 1'b0;
        @(negedge clk);
        chk("wrap_grp_cnt", 64'(bus.grp_cnt_o), 64'(1));
        cyc(3);
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
